// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file and its scoreboard.
// Holds default geometry, the zero-register index, and the rs1/rs2/rd field
// positions so decode and the register file agree on one source of truth.
package regfile_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned NREGS_DEF   = 32;
    localparam int unsigned NUM_RD_DEF  = 2;

    localparam int unsigned ZERO_REG    = 0;

    // Register specifier fields in the 32-bit instruction word.
    localparam int unsigned REG_FIELD_W = 5;
    localparam int unsigned RS1_LSB     = 15;  // rs1 = insn[19:15]
    localparam int unsigned RS2_LSB     = 20;  // rs2 = insn[24:20]
    localparam int unsigned RD_LSB      = 7;   // rd  = insn[11:7]

    typedef struct packed {
        logic [REG_FIELD_W-1:0] rs1;
        logic [REG_FIELD_W-1:0] rs2;
        logic [REG_FIELD_W-1:0] rd;
    } reg_fields_t;

    // Extract all register specifiers from one instruction word.
    function automatic reg_fields_t decode_reg_fields(input logic [31:0] insn);
        reg_fields_t f;
        f.rs1 = insn[RS1_LSB +: REG_FIELD_W];
        f.rs2 = insn[RS2_LSB +: REG_FIELD_W];
        f.rd  = insn[RD_LSB  +: REG_FIELD_W];
        return f;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Issue sets the destination bit, write-back clears it; a same-cycle set and
// clear of one register leaves it set. Produces per-port busy, the decode
// stall and a sticky error for write-backs to registers that were not busy.
// Optional: REGFILE_BYPASS_EN lets a same-cycle write-back hide the hazard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NUM_RD = NUM_RD_DEF,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    input  logic                 iss_valid_i,
    input  logic [AW-1:0]        iss_rd_i,
    input  logic                 wb_valid_i,
    input  logic [AW-1:0]        wb_addr_i,
    output logic [NUM_RD-1:0]    rd_busy_o,
    output logic                 stall_o,
    output logic                 err_o
);

    logic [NREGS-1:0]  r_busy;
    logic              r_err;

    logic              w_wb_en;
    logic              w_byp_dst;
    logic              w_dst_busy;
    logic              w_accept;
    logic [NUM_RD-1:0] w_byp_src;
    logic [NUM_RD-1:0] w_src_busy;
    logic [NREGS-1:0]  w_busy_nxt;

    assign w_wb_en = wb_valid_i && (wb_addr_i != AW'(ZERO_REG));

    // Per-port source hazard, optionally hidden by a matching write-back.
    always_comb begin
        w_byp_src  = '0;
        w_src_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_src_busy[k] = r_busy[rd_addr_i[k*AW +: AW]] &&
                            (rd_addr_i[k*AW +: AW] != AW'(ZERO_REG));
`ifdef REGFILE_BYPASS_EN
            w_byp_src[k]  = w_wb_en && (wb_addr_i == rd_addr_i[k*AW +: AW]);
`else
            w_byp_src[k]  = 1'b0;
`endif
        end
    end

    // Destination (WAW) hazard, optionally hidden by a matching write-back.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        w_byp_dst  = w_wb_en && (wb_addr_i == iss_rd_i);
`else
        w_byp_dst  = 1'b0;
`endif
        w_dst_busy = (iss_rd_i != AW'(ZERO_REG)) && r_busy[iss_rd_i] && !w_byp_dst;
    end

    assign rd_busy_o = w_src_busy & ~w_byp_src;
    assign stall_o   = iss_valid_i && ((|rd_busy_o) || w_dst_busy);
    assign w_accept  = iss_valid_i && !stall_o && (iss_rd_i != AW'(ZERO_REG));
    assign err_o     = r_err;

    // Next busy vector: clear on write-back first, then set on issue so set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_en) begin
            w_busy_nxt[wb_addr_i] = 1'b0;
        end
        if (w_accept) begin
            w_busy_nxt[iss_rd_i] = 1'b1;
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    // Busy vector and sticky error register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_wb_en && !r_busy[wb_addr_i]) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with pending-write scoreboard.
// NUM_RD combinational read ports, one clocked write port, register 0 reads
// as zero. Hazard tracking lives in regfile_scoreboard.
// Optional: define REGFILE_BYPASS_EN to forward a same-cycle write-back onto
// matching read ports (and clear the associated busy/stall in that cycle).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NUM_RD = NUM_RD_DEF,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic                   iss_valid_i,
    input  logic [AW-1:0]          iss_rd_i,
    input  logic                   wb_valid_i,
    input  logic [AW-1:0]          wb_addr_i,
    input  logic [XLEN-1:0]        wb_data_i,
    output logic                   stall_o,
    output logic                   err_o
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wb_en;

    assign w_wb_en = wb_valid_i && (wb_addr_i != AW'(ZERO_REG));

    // Storage array: asynchronous clear, single write port, register 0 never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Read muxes with zero-register forcing and optional write-back forwarding.
    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (rd_addr_i[k*AW +: AW] != AW'(ZERO_REG)) begin
                rd_data_o[k*XLEN +: XLEN] = r_regs[rd_addr_i[k*AW +: AW]];
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wb_en && (wb_addr_i == rd_addr_i[k*AW +: AW])) begin
                rd_data_o[k*XLEN +: XLEN] = wb_data_i;
            end
`endif
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .rd_addr_i   (rd_addr_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .wb_valid_i  (wb_valid_i),
        .wb_addr_i   (wb_addr_i),
        .rd_busy_o   (rd_busy_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

endmodule
